// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryptor: one round per clock, on-the-fly key schedule, 11-cycle latency.
// Define AES_ENC_CBC_EN to add the iv/iv_load chaining register (CBC); the default build is ECB.
module aes128_encrypt_iter #(
  parameter int NUM_ROUNDS = 10,
  parameter int CNT_W      = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] key,
  input  logic [127:0] plaintext,
`ifdef AES_ENC_CBC_EN
  input  logic [127:0] iv,
  input  logic         iv_load,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  // Entry 0 sits in the top byte, so entry x lives at bit offset 8*(255-x).
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  function automatic logic [7:0] rcon(input logic [CNT_W-1:0] r);
    case (r)
      CNT_W'(1):  return 8'h01;
      CNT_W'(2):  return 8'h02;
      CNT_W'(3):  return 8'h04;
      CNT_W'(4):  return 8'h08;
      CNT_W'(5):  return 8'h10;
      CNT_W'(6):  return 8'h20;
      CNT_W'(7):  return 8'h40;
      CNT_W'(8):  return 8'h80;
      CNT_W'(9):  return 8'h1b;
      CNT_W'(10): return 8'h36;
      default:    return 8'h00;
    endcase
  endfunction

  fsm_t             fsm, fsm_next;
  logic [127:0]     state_reg, rkey, rkey_next, chain;
  logic [127:0]     sb, sr, mc, round_out;
  logic [31:0]      tmp, k0, k1, k2, k3;
  logic [CNT_W-1:0] rnd;
  logic             accept, last_rnd, iv_take;

  assign last_rnd = (rnd == CNT_W'(NUM_ROUNDS));

  always_comb begin
    tmp = {sbox(rkey[23:16]), sbox(rkey[15:8]), sbox(rkey[7:0]), sbox(rkey[31:24])}
          ^ {rcon(rnd), 24'h000000};
    k0 = rkey[127:96] ^ tmp;
    k1 = rkey[95:64] ^ k0;
    k2 = rkey[63:32] ^ k1;
    k3 = rkey[31:0] ^ k2;
    rkey_next = {k0, k1, k2, k3};
  end

  // Byte k of the column-major state is at [127-8k -: 8]; row r of column c is byte r+4c.
  always_comb begin
    sb = '0;
    sr = '0;
    mc = '0;
    for (int i = 0; i < 16; i++) sb[8*i +: 8] = sbox(state_reg[8*i +: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
    for (int c = 0; c < 4; c++) mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
    round_out = (last_rnd ? sr : mc) ^ rkey_next;
  end

  always_ff @(posedge clk) begin
    if (rst) fsm <= IDLE;
    else     fsm <= fsm_next;
  end

  always_comb begin
    fsm_next  = fsm;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (fsm)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid && !iv_take;
        if (accept) fsm_next = ROUND;
      end
      ROUND: if (last_rnd) fsm_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) fsm_next = IDLE;
      end
      default: fsm_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= '0;
      rkey       <= '0;
      rnd        <= '0;
      ciphertext <= '0;
    end else begin
      if (accept) begin
        state_reg <= plaintext ^ chain ^ key;
        rkey      <= key;
        rnd       <= CNT_W'(1);
      end
      if (fsm == ROUND) begin
        state_reg <= round_out;
        rkey      <= rkey_next;
        rnd       <= rnd + CNT_W'(1);
        if (last_rnd) ciphertext <= round_out;
      end
    end
  end

`ifdef AES_ENC_CBC_EN
  logic [127:0] cbc_reg;

  assign iv_take = (fsm == IDLE) && iv_load;
  assign chain   = cbc_reg;

  // The chain value advances when the ciphertext is handed off downstream.
  always_ff @(posedge clk) begin
    if (rst)                         cbc_reg <= '0;
    else if (iv_take)                cbc_reg <= iv;
    else if (out_valid && out_ready) cbc_reg <= ciphertext;
  end
`else
  assign iv_take = 1'b0;
  assign chain   = '0;
`endif

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// Self-checking bench for aes128_encrypt_iter: known-answer table, backpressure, back-to-back, abort.
module tb_aes128_encrypt_iter;
  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [127:0] key, plaintext, ciphertext;
`ifdef AES_ENC_CBC_EN
  logic [127:0] iv;
  logic         iv_load;
`endif

  always #5 clk = ~clk;

  aes128_encrypt_iter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .key(key), .plaintext(plaintext),
`ifdef AES_ENC_CBC_EN
    .iv(iv), .iv_load(iv_load),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .ciphertext(ciphertext)
  );

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  vec_t         vecs [7];
  logic [127:0] exp_q [$];
  int           acc_q [$];
  int           n_cmp = 0, n_bad = 0, cyc = 0;
  int           last_acc = 0, last_hs = 0, rises = 0;
  logic [127:0] drv_exp = '0, prev_ct = '0;
  logic         prev_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor samples at negedge; the values seen here are what the next posedge acts on.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
      prev_ov = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(drv_exp);
        acc_q.push_back(cyc + 1);
        last_acc = cyc + 1;
      end
      if (out_valid && !prev_ov) begin
        rises++;
        if (acc_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rise_without_accept: out_valid rose at edge %0d, required no output", cyc + 1);
        end else check("latency", 128'(cyc + 1 - acc_q[0]), 128'd11);
      end
      if (out_valid && prev_ov) check("ct_stable", ciphertext, prev_ct);
      if (out_valid && out_ready) begin
        last_hs = cyc + 1;
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL spurious_output: got %h with no block outstanding", ciphertext);
        end else begin
          check("ciphertext", ciphertext, exp_q.pop_front());
          void'(acc_q.pop_front());
        end
      end
      prev_ov = out_valid;
      prev_ct = ciphertext;
    end
  end

  task automatic send(input vec_t v, input bit hold, output int acc_edge);
    bit done = 1'b0;
    acc_edge = -1;
    @(posedge clk); #1;
    key = v.key; plaintext = v.pt; drv_exp = v.ct; in_valid = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acc_edge = cyc + 1;
        done = 1'b1;
      end
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1 within 60 cycles");
    end
    @(posedge clk); #1;
    if (!hold) begin
      in_valid  = 1'b0;
      key       = {$urandom, $urandom, $urandom, $urandom};
      plaintext = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain", 128'(exp_q.size()), 128'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2, r0, acc_bp;
    bit seen;
    vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                128'h3925841d02dc09fbdc118597196a0b32};
    vecs[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h6bc1bee22e409f96e93d7e117393172a,
                128'h3ad77bb40d7a3660a89ecaf32466ef97};
    vecs[3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
                128'hf5d3d58503b9699de785895a96fdbaaf};
    vecs[4] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h30c81c46a35ce411e5fbc1191a0a52ef,
                128'h43b1cd7f598ece23881b00e3ed030688};
    vecs[5] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hf69f2445df4f9b17ad2b417be66c3710,
                128'h7b0c785e27e8ad3f8223207104725dd4};
    vecs[6] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; key = '0; plaintext = '0;
`ifdef AES_ENC_CBC_EN
    iv = '0; iv_load = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 128'(in_ready), 128'd1);
    check("reset_out_valid", 128'(out_valid), 128'd0);
    check("reset_ciphertext", ciphertext, 128'd0);
    rst = 1'b0;
    out_ready = 1'b1;

`ifdef AES_ENC_CBC_EN
    // Chained blocks with a non-zero IV.
    @(posedge clk); #1;
    iv = 128'h000102030405060708090a0b0c0d0e0f; iv_load = 1'b1;
    @(posedge clk); #1;
    iv_load = 1'b0;
    send('{vecs[2].key, vecs[2].pt, 128'h7649abac8119b246cee98e9b12e9197d}, 1'b0, a0);
    drain();
    send('{vecs[3].key, vecs[3].pt, 128'h5086cb9b507219ee95db113a917678b2}, 1'b0, a1);
    drain();
`else
    for (int i = 0; i < 7; i++) begin
      send(vecs[i], 1'b0, a0);
      drain();
    end

    // Backpressure: hold the result for 20 cycles with a second request pending.
    out_ready = 1'b0;
    send(vecs[0], 1'b0, a0);
    @(posedge clk); #1;
    key = vecs[1].key; plaintext = vecs[1].pt; drv_exp = vecs[1].ct; in_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    check("bp_out_valid_seen", 128'(seen), 128'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i % 5 == 0) check("bp_in_ready", 128'(in_ready), 128'd0);
    end
    check("bp_no_accept", 128'(last_acc), 128'(a0));
    @(posedge clk); #1;
    out_ready = 1'b1;
    acc_bp = -1;
    for (int i = 0; i < 10 && acc_bp < 0; i++) begin
      @(negedge clk);
      if (in_ready) acc_bp = cyc + 1;
    end
    check("bp_accept_after_hs", 128'(acc_bp - last_hs), 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // Back-to-back with in_valid and out_ready held high.
    send(vecs[2], 1'b1, a0);
    send(vecs[3], 1'b1, a1);
    send(vecs[4], 1'b0, a2);
    check("b2b_spacing_1", 128'(a1 - a0), 128'd12);
    check("b2b_spacing_2", 128'(a2 - a1), 128'd12);
    drain();

    // Abort at round 5, then a fresh block must still be correct.
    send(vecs[0], 1'b0, a0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready", 128'(in_ready), 128'd1);
    check("abort_out_valid", 128'(out_valid), 128'd0);
    r0 = rises;
    repeat (20) @(negedge clk);
    check("abort_no_rise", 128'(rises), 128'(r0));
    send(vecs[0], 1'b0, a0);
    drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
